mul_accum: RTL and testbench
============================

Name: mul_accum

Overview:
- Accumulator stage directly downstream of the 16x16 unsigned multiplier (`mul16`, built from four `mul8` quarter-products).
- The multiplier has fixed latency and no valid signal. This block tracks which cycles carry real products using a valid delay line matched to that latency.
- It sums N_TERMS products into a wide accumulator with saturation and presents each finished dot-product with a one-cycle valid pulse.
- It feeds the writeback and result register stage.

Parameters:
- MUL_LAT, 2: cycles from operands entering the multiplier to the product on `prod`; legal range 1..8.
- N_TERMS, 8: products per dot-product; legal range 1..255.
- ACC_W, 40: accumulator and result width; legal range 33..48.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a,b presented to the multiplier this cycle.
- flush  in  1  force early completion of the current dot-product.
- prod  in  32  multiplier result; unsigned; meaningful only MUL_LAT cycles after in_valid.
- out_valid  out  1  one-cycle pulse: out_acc, out_count and out_sat are new.
- out_acc  out  ACC_W  completed sum; held until the next completion.
- out_count  out  8  number of products in out_acc.
- out_sat  out  1  saturation occurred during this dot-product.
- busy  out  1  delay line non-empty or partial sum pending.

Behaviour:
- Reset:
  - The only reset is clk-synchronous and active-high.
  - Clears: delay line, acc, cnt, sat_sticky, pend_flush, out_valid, out_acc, out_count, out_sat, busy.
  - Reset mid-operation discards in-flight products and the partial sum; no out_valid is produced.
- Delay line:
  - MUL_LAT-deep shift register of in_valid.
  - Tap p_valid is in_valid delayed by exactly MUL_LAT cycles.
  - Back-to-back in_valid is supported, one product per cycle.
- Accumulate:
  - When p_valid=1, sum = acc + zero_ext(prod) is computed ACC_W+1 bits wide.
  - If sum[ACC_W]=1, the accumulator takes all-ones and sat_sticky is set.
  - cnt increments.
- Completion: occurs in cycle k when p_valid=1 and cnt+1==N_TERMS. At the end of cycle k:
  - out_acc takes the (saturated) sum.
  - out_count takes cnt+1.
  - out_sat takes sat_sticky OR this cycle's overflow.
  - acc, cnt and sat_sticky clear.
  - out_valid=1 during cycle k+1 only.
- Flush:
  - flush is sampled and latched into pend_flush.
  - Completion is forced at the first cycle in which the delay line holds no valid stages, i.e. after every product already issued has been accumulated.
  - out_count then reports the actual count (0..N_TERMS-1). Flush with cnt=0 and an empty line still emits out_valid with out_acc=0 and out_count=0.
  - If a natural completion and the flush drain happen in the same cycle, a single result is emitted, and pend_flush clears.
  - in_valid asserted while pend_flush=1 is legal; those products belong to the next dot-product and do not delay the flush.
- Outputs:
  - out_acc and out_count are registered and stable between pulses.
  - out_valid is never high two consecutive cycles unless two completions occur back-to-back (N_TERMS=1).
- busy = (any delay-line stage =1) OR (cnt!=0) OR pend_flush.
- No backpressure: the consumer must accept every out_valid pulse.

Test Plan:
- Default parameters; in_valid for 8 consecutive cycles starting at cycle t; model drives prod=15 (3*5) exactly 2 cycles after each → out_valid in cycle t+10 only, out_acc=120, out_count=8, out_sat=0; busy low at t+10.
- in_valid gapped (cycles t, t+3, t+4, t+9, ...) for 8 terms, prod=0xFFFE0001 each (0xFFFF*0xFFFF) → out_acc=0x7_FFF0_0008, out_count=8; no intermediate out_valid.
- ACC_W=33, N_TERMS=3, prod=0xFFFF_FFFF three times → out_acc=0x1_FFFF_FFFF, out_sat=1. The next dot-product of 3x1 → out_acc=3, out_sat=0 (sticky cleared).
- 3 products of 100 issued, flush pulsed the same cycle as the third in_valid → single out_valid after the third product accumulates, out_acc=300, out_count=3. flush on an idle block → out_valid next cycle with out_acc=0, out_count=0.
- N_TERMS=1, in_valid every cycle with prod=7,8,9 → out_valid high three consecutive cycles with out_acc=7,8,9.
- 5 of 8 products accumulated, 2 in flight, reset asserted one cycle → no out_valid; busy=0 after reset. A fresh 8-term run of 1s → out_acc=8, with no residue from the aborted run.

Source files
------------

// File: rtl/mul_accum.sv
// Accumulates fixed-latency multiplier products into saturating dot-products,
// tracking product validity with a delay line matched to the multiplier latency.
module mul_accum #(
  parameter int MUL_LAT = 2,
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [31:0]      prod,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_count,
  output logic             out_sat,
  output logic             busy
);

  localparam logic [8:0] N_LAST = 9'(N_TERMS);

  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic [MUL_LAT-1:0] own_q, own_d, own_sh;
  logic [ACC_W-1:0]   acc_q, acc_d, out_acc_q, out_acc_d, acc_new;
  logic [7:0]         cnt_q, cnt_d, out_count_q, out_count_d, cnt_new;
  logic               sat_q, sat_d, sat_new;
  logic               pend_q, pend_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sat_q, out_sat_d;
  logic               busy_q, busy_d;
  logic               p_valid, ovf;
  logic [ACC_W:0]     sum;
  logic               flush_req, drain_done, natural_done, done;

  always_comb begin
    p_valid = vld_q[MUL_LAT-1];
    vld_d   = (vld_q << 1) | MUL_LAT'(in_valid);

    sum     = {1'b0, acc_q} + (ACC_W+1)'(prod);
    ovf     = p_valid & sum[ACC_W];
    acc_new = acc_q;
    cnt_new = cnt_q;
    if (p_valid) begin
      acc_new = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      cnt_new = cnt_q + 8'd1;
    end
    sat_new      = sat_q | ovf;
    natural_done = p_valid && ({1'b0, cnt_new} == N_LAST);

    // own_* marks in-flight products that belong to the dot-product being
    // flushed; products issued while a flush is pending go to the next one.
    own_sh     = (own_q << 1) | MUL_LAT'(in_valid & ~pend_q);
    flush_req  = flush | pend_q;
    drain_done = flush_req & ~(|own_sh);
    done       = natural_done | drain_done;

    own_d  = drain_done ? vld_d : own_sh;
    pend_d = flush_req & ~drain_done;

    acc_d = done ? '0    : acc_new;
    cnt_d = done ? 8'd0  : cnt_new;
    sat_d = done ? 1'b0  : sat_new;

    out_valid_d = done;
    out_acc_d   = done ? acc_new : out_acc_q;
    out_count_d = done ? cnt_new : out_count_q;
    out_sat_d   = done ? sat_new : out_sat_q;

    busy_d = (|vld_d) | (cnt_d != 8'd0) | pend_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      own_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      own_q       <= own_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_accum.sv
// Bench for mul_accum: three instances (default, narrow saturating, single-term)
// checked every cycle against a transaction-level model, plus literal pulses.
module tb_mul_accum;

  logic        clk;
  logic        reset;
  logic        iv  [3];
  logic        fl  [3];
  logic [31:0] pr  [3];
  logic        ov  [3];
  logic [7:0]  ocnt[3];
  logic        osat[3];
  logic        obusy[3];
  logic [39:0] oacc0;
  logic [32:0] oacc1;
  logic [39:0] oacc2;
  logic [63:0] act_acc[3];

  assign act_acc[0] = 64'(oacc0);
  assign act_acc[1] = 64'(oacc1);
  assign act_acc[2] = 64'(oacc2);

  mul_accum #(.MUL_LAT(2), .N_TERMS(8), .ACC_W(40)) d0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .flush(fl[0]), .prod(pr[0]),
    .out_valid(ov[0]), .out_acc(oacc0), .out_count(ocnt[0]), .out_sat(osat[0]), .busy(obusy[0]));
  mul_accum #(.MUL_LAT(2), .N_TERMS(3), .ACC_W(33)) d1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .flush(fl[1]), .prod(pr[1]),
    .out_valid(ov[1]), .out_acc(oacc1), .out_count(ocnt[1]), .out_sat(osat[1]), .busy(obusy[1]));
  mul_accum #(.MUL_LAT(2), .N_TERMS(1), .ACC_W(40)) d2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .flush(fl[2]), .prod(pr[2]),
    .out_valid(ov[2]), .out_acc(oacc2), .out_count(ocnt[2]), .out_sat(osat[2]), .busy(obusy[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  function automatic int n_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 3 : 1;
  endfunction

  function automatic logic [63:0] max_of(input int i);
    return (i == 1) ? ((64'd1 << 33) - 64'd1) : ((64'd1 << 40) - 64'd1);
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  // transaction model: products in flight with their arrival cycle
  typedef struct {
    int          inst;
    int          arr;
    logic [31:0] val;
    bit          nxt;
  } fl_t;
  fl_t fl_q[$];

  logic [31:0] iv_val[3];
  logic [63:0] m_acc [3];
  int          m_cnt [3];
  bit          m_sat [3];
  bit          m_pend[3];
  bit          e_valid[3];
  logic [63:0] e_acc [3];
  int          e_cnt [3];
  bit          e_sat [3];

  task automatic model_update(input int c);
    for (int i = 0; i < 3; i++) begin
      bit          arrived;
      bit          req;
      bit          natural_c;
      bit          drain;
      int          owned;
      logic [31:0] v;
      logic [63:0] s;
      arrived = 1'b0;
      v       = '0;
      if (reset) begin
        for (int k = fl_q.size() - 1; k >= 0; k--)
          if (fl_q[k].inst == i) fl_q.delete(k);
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_pend[i] = 0;
        e_valid[i] = 0; e_acc[i] = 0; e_cnt[i] = 0; e_sat[i] = 0;
        continue;
      end
      for (int k = 0; k < fl_q.size(); k++) begin
        if (fl_q[k].inst == i && fl_q[k].arr == c) begin
          v = fl_q[k].val;
          fl_q.delete(k);
          arrived = 1'b1;
          break;
        end
      end
      if (iv[i]) fl_q.push_back('{inst: i, arr: c + 2, val: iv_val[i], nxt: m_pend[i]});
      req   = fl[i] || m_pend[i];
      owned = 0;
      for (int k = 0; k < fl_q.size(); k++)
        if (fl_q[k].inst == i && !fl_q[k].nxt) owned++;
      natural_c = 1'b0;
      if (arrived) begin
        s = m_acc[i] + 64'(v);
        if (s > max_of(i)) begin
          m_acc[i] = max_of(i);
          m_sat[i] = 1'b1;
        end else begin
          m_acc[i] = s;
        end
        m_cnt[i]++;
        natural_c = (m_cnt[i] == n_of(i));
      end
      drain      = req && (owned == 0);
      e_valid[i] = 1'b0;
      if (natural_c || drain) begin
        e_valid[i] = 1'b1;
        e_acc[i]   = m_acc[i];
        e_cnt[i]   = m_cnt[i];
        e_sat[i]   = m_sat[i];
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
        if (drain)
          for (int k = 0; k < fl_q.size(); k++)
            if (fl_q[k].inst == i) fl_q[k].nxt = 1'b0;
      end
      m_pend[i] = req && !drain;
    end
  endtask

  function automatic bit m_busy(input int i);
    bit b;
    b = (m_cnt[i] != 0) || m_pend[i];
    foreach (fl_q[k]) if (fl_q[k].inst == i) b = 1'b1;
    return b;
  endfunction

  // scoreboard: per-cycle compare plus a log of observed pulses
  typedef struct {
    int          inst;
    int          cyc;
    logic [63:0] acc;
    logic [7:0]  cnt;
    logic        sat;
  } pulse_t;
  pulse_t pulse_q[$];
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("out_valid", i, 64'(ov[i]),    64'(e_valid[i]));
        chk("out_acc",   i, act_acc[i],    e_acc[i]);
        chk("out_count", i, 64'(ocnt[i]),  64'(e_cnt[i]));
        chk("out_sat",   i, 64'(osat[i]),  64'(e_sat[i]));
        chk("busy",      i, 64'(obusy[i]), 64'(m_busy(i)));
        if (ov[i] === 1'b1)
          pulse_q.push_back('{inst: i, cyc: cyc, acc: act_acc[i], cnt: ocnt[i], sat: osat[i]});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_update(cyc);
    cyc++;
    #1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      fl[i] = 1'b0;
      pr[i] = $urandom();
      foreach (fl_q[k]) if (fl_q[k].inst == i && fl_q[k].arr == cyc) pr[i] = fl_q[k].val;
    end
  endtask

  task automatic issue(input int i, input logic [31:0] v);
    iv[i]     = 1'b1;
    iv_val[i] = v;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_pulse(input int i, input int c, input logic [63:0] acc,
                              input int cnt, input bit sat);
    pulse_t p;
    exp_q.push_back(acc);
    checks++;
    if (pulse_q.size() == 0) begin
      errors++;
      $display("FAIL pulse_missing[%0d]: got none expected acc %0h at cycle %0d", i, acc, c);
      void'(exp_q.pop_front());
      return;
    end
    p = pulse_q.pop_front();
    chk("pulse_inst",  i, 64'(p.inst), 64'(i));
    chk("pulse_cycle", i, 64'(p.cyc),  64'(c));
    chk("pulse_acc",   i, p.acc,       exp_q.pop_front());
    chk("pulse_count", i, 64'(p.cnt),  64'(cnt));
    chk("pulse_sat",   i, 64'(p.sat),  64'(sat));
  endtask

  task automatic expect_none(input string nm);
    chk(nm, 0, 64'(pulse_q.size()), 64'd0);
    pulse_q.delete();
  endtask

  initial begin
    int t;
    int gap_tab[8] = '{0, 3, 4, 9, 10, 11, 15, 20};
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; fl[i] = 1'b0; pr[i] = '0; iv_val[i] = '0;
      m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_pend[i] = 0;
      e_valid[i] = 0; e_acc[i] = 0; e_cnt[i] = 0; e_sat[i] = 0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    expect_none("no_pulse_reset");

    // eight back-to-back products of 15
    t = cyc;
    for (int k = 0; k < 8; k++) begin issue(0, 32'd15); tick(); end
    run_to(t + 13);
    expect_pulse(0, t + 10, 64'd120, 8, 1'b0);
    expect_none("single_pulse_b2b");

    // gapped issue of 0xFFFE0001
    t = cyc;
    for (int k = 0; k <= 20; k++) begin
      foreach (gap_tab[j]) if (gap_tab[j] == k) issue(0, 32'hFFFE_0001);
      tick();
    end
    run_to(t + 25);
    expect_pulse(0, t + 23, 64'h7_FFF0_0008, 8, 1'b0);
    expect_none("single_pulse_gapped");

    // saturation in the 33-bit instance, then sticky cleared
    t = cyc;
    for (int k = 0; k < 3; k++) begin issue(1, 32'hFFFF_FFFF); tick(); end
    for (int k = 0; k < 3; k++) begin issue(1, 32'd1); tick(); end
    run_to(t + 10);
    expect_pulse(1, t + 5, 64'h1_FFFF_FFFF, 3, 1'b1);
    expect_pulse(1, t + 8, 64'd3, 3, 1'b0);
    expect_none("sat_runs");

    // flush together with the third issue, then flush on an idle block
    t = cyc;
    issue(0, 32'd100); tick();
    issue(0, 32'd100); tick();
    issue(0, 32'd100); fl[0] = 1'b1; tick();
    run_to(t + 8);
    expect_pulse(0, t + 5, 64'd300, 3, 1'b0);
    expect_none("flush_single");
    t = cyc;
    fl[0] = 1'b1; tick();
    run_to(t + 3);
    expect_pulse(0, t + 1, 64'd0, 0, 1'b0);
    expect_none("idle_flush_single");

    // single-term instance emits every cycle
    t = cyc;
    issue(2, 32'd7); tick();
    issue(2, 32'd8); tick();
    issue(2, 32'd9); tick();
    run_to(t + 7);
    expect_pulse(2, t + 3, 64'd7, 1, 1'b0);
    expect_pulse(2, t + 4, 64'd8, 1, 1'b0);
    expect_pulse(2, t + 5, 64'd9, 1, 1'b0);
    expect_none("n1_pulses");

    // reset mid-operation, then a clean run of ones
    t = cyc;
    for (int k = 0; k < 7; k++) begin issue(0, 32'd50); tick(); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("busy_after_reset", 0, 64'(obusy[0]), 64'd0);
    run_to(t + 14);
    expect_none("no_pulse_after_abort");
    t = cyc;
    for (int k = 0; k < 8; k++) begin issue(0, 32'd1); tick(); end
    run_to(t + 13);
    expect_pulse(0, t + 10, 64'd8, 8, 1'b0);
    expect_none("fresh_run");

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
